// File: rtl/tiny_fpga_pkg.sv
// Shared types and constants for the tiny FPGA configuration path.
package tiny_fpga_pkg;

  // Loader FSM state. The encoding is 3 bits wide, so the unused codes 5..7 exist
  // and must fall back to IDLE.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARM   = 3'd1,
    ST_SHIFT = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } t_loader_state;

  // Default geometry of the 2x2 fabric.
  localparam int DEF_CLB_COUNT     = 4;
  localparam int DEF_WORDS_PER_CLB = 3;
  localparam int TOTAL_WORDS       = DEF_CLB_COUNT * DEF_WORDS_PER_CLB;

  // Width of a counter that runs 0..limit-1. The result is never below 1 bit.
  function automatic int clog2_min1(input int limit);
    return (limit <= 2) ? 1 : $clog2(limit);
  endfunction

endpackage

// File: rtl/cfg_bitstream_loader_axis_fifo.sv
// Small synchronous FIFO that holds {tlast, tdata} between AXI-stream stages.
// A push and a pop in the same cycle are both honoured, even when the FIFO is full.
module axis_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  output logic             o_full,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_pop_data,
  output logic             o_empty
);

  localparam int AW = (DEPTH <= 2) ? 1 : $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  // The pointers carry one extra wrap bit, which separates the full case from the empty case.
  assign o_empty    = (r_wr_ptr == r_rd_ptr);
  assign o_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_pop   = i_pop && !o_empty;
  assign w_do_push  = i_push && (!o_full || w_do_pop);
  assign o_pop_data = r_mem[r_rd_ptr[AW-1:0]];

  // Pointer update. Reset empties the FIFO and discards any stored words.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage write. The stored data has no reset, because the pointers decide what is valid.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
  end

endmodule

// File: rtl/cfg_bitstream_loader.sv
// Deserialises an asynchronous pin-level bitstream into framed AXI-stream words
// for the fabric configuration port. It also issues the one-cycle cfg request.
module cfg_bitstream_loader
  import tiny_fpga_pkg::*;
#(
  parameter int BITSTREAM_DATA_WIDTH = 8,
  parameter int CLB_COUNT            = DEF_CLB_COUNT,
  parameter int WORDS_PER_CLB        = DEF_WORDS_PER_CLB,
  parameter int SYNC_STAGES          = 2,
  parameter int FIFO_DEPTH           = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            i_load_start,
  input  logic                            i_ser_clk,
  input  logic                            i_ser_data,
  output logic                            o_cfg,
  output logic                            o_tvalid,
  input  logic                            i_tready,
  output logic [BITSTREAM_DATA_WIDTH-1:0] o_tdata,
  output logic                            o_tlast,
  output logic                            o_busy,
  output logic                            o_done,
  output logic                            o_error
);

  localparam int W  = BITSTREAM_DATA_WIDTH;
  localparam int BW = clog2_min1(W);
  localparam int WW = clog2_min1(WORDS_PER_CLB);
  localparam int FW = clog2_min1(CLB_COUNT);

  t_loader_state          r_state;
  t_loader_state          w_next;
  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_sdat_sync;
  logic                   r_sclk_d;
  logic [W-2:0]           r_shreg;
  logic [BW-1:0]          r_bit_cnt;
  logic [WW-1:0]          r_word_cnt;
  logic [FW-1:0]          r_frame_cnt;
  logic                   r_error;
  logic                   w_edge;
  logic                   w_bit;
  logic                   w_word_done;
  logic                   w_word_last;
  logic                   w_last_word;
  logic                   w_push;
  logic [W:0]             w_push_data;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_pop;
  logic [W:0]             w_pop_data;

  // Both serial inputs pass through the same number of flops, so each sampled bit
  // stays aligned with the clock edge that qualifies it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sclk_sync <= '0;
      r_sdat_sync <= '0;
      r_sclk_d    <= 1'b0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], i_ser_clk};
      r_sdat_sync <= {r_sdat_sync[SYNC_STAGES-2:0], i_ser_data};
      r_sclk_d    <= r_sclk_sync[SYNC_STAGES-1];
    end
  end

  assign w_edge      = r_sclk_sync[SYNC_STAGES-1] & ~r_sclk_d;
  assign w_bit       = r_sdat_sync[SYNC_STAGES-1];
  assign w_word_done = (r_state == ST_SHIFT) && w_edge && (r_bit_cnt == BW'(W - 1));
  assign w_word_last = (r_word_cnt == WW'(WORDS_PER_CLB - 1));
  assign w_last_word = w_word_last && (r_frame_cnt == FW'(CLB_COUNT - 1));
  assign w_push      = w_word_done;
  assign w_push_data = {w_word_last, r_shreg, w_bit};
  assign w_pop       = o_tvalid && i_tready;

  // The AXI-stream outputs come straight from the FIFO head. tdata reads 0 while nothing is valid.
  assign o_tvalid = !w_empty;
  assign o_tdata  = o_tvalid ? w_pop_data[W-1:0] : '0;
  assign o_tlast  = o_tvalid & w_pop_data[W];
  assign o_error  = r_error;

  axis_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (W + 1)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_push),
    .i_push_data (w_push_data),
    .o_full      (w_full),
    .i_pop       (w_pop),
    .o_pop_data  (w_pop_data),
    .o_empty     (w_empty)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Next-state and Moore outputs. load_start is honoured only in IDLE or DONE.
  always_comb begin
    w_next = r_state;
    o_cfg  = 1'b0;
    o_busy = 1'b0;
    o_done = 1'b0;
    case (r_state)
      ST_IDLE:  if (i_load_start) w_next = ST_ARM;
      ST_ARM: begin
        o_cfg  = 1'b1;
        o_busy = 1'b1;
        w_next = ST_SHIFT;
      end
      ST_SHIFT: begin
        o_busy = 1'b1;
        if (w_word_done && w_last_word) w_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        o_busy = 1'b1;
        if (w_empty) w_next = ST_DONE;
      end
      ST_DONE: begin
        o_done = 1'b1;
        if (i_load_start) w_next = ST_ARM;
      end
      default:  w_next = ST_IDLE;
    endcase
  end

  // Shift register and framing counters. They clear on ARM and advance only on edges
  // detected in SHIFT. Dropped words still advance the counters, so framing keeps
  // following the serial stream.
  always_ff @(posedge clk) begin
    if (!rst_n || r_state == ST_ARM) begin
      r_shreg     <= '0;
      r_bit_cnt   <= '0;
      r_word_cnt  <= '0;
      r_frame_cnt <= '0;
    end else if (r_state == ST_SHIFT && w_edge) begin
      r_shreg <= {r_shreg[W-3:0], w_bit};
      if (r_bit_cnt == BW'(W - 1)) begin
        r_bit_cnt <= '0;
        if (w_word_last) begin
          r_word_cnt <= '0;
          if (!w_last_word) r_frame_cnt <= r_frame_cnt + FW'(1);
        end else begin
          r_word_cnt <= r_word_cnt + WW'(1);
        end
      end else begin
        r_bit_cnt <= r_bit_cnt + BW'(1);
      end
    end
  end

  // Sticky overflow flag. It is set when a word is pushed into a full FIFO that is not
  // popping in the same cycle, and it clears when a new load is armed.
  always_ff @(posedge clk) begin
    if (!rst_n || r_state == ST_ARM) r_error <= 1'b0;
    else if (w_push && w_full && !w_pop) r_error <= 1'b1;
  end

endmodule

// File: tb/tb_cfg_bitstream_loader.sv
// Bench for cfg_bitstream_loader: table-driven word vectors, a scoreboard queue,
// and hand-written sequences for reset, backpressure, overflow, restart and reload.
module tb_cfg_bitstream_loader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       i_load_start;
  logic       i_ser_clk;
  logic       i_ser_data;
  logic       o_cfg;
  logic       o_tvalid;
  logic       i_tready;
  logic [7:0] o_tdata;
  logic       o_tlast;
  logic       o_busy;
  logic       o_done;
  logic       o_error;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [7:0] data;
    logic       last;
  } vec_t;

  vec_t       tbl [12];
  logic [8:0] sb_q [$];
  logic       prev_stall = 1'b0;
  logic [8:0] prev_word  = '0;

  always #5 clk = ~clk;

  cfg_bitstream_loader dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_load_start (i_load_start),
    .i_ser_clk    (i_ser_clk),
    .i_ser_data   (i_ser_data),
    .o_cfg        (o_cfg),
    .o_tvalid     (o_tvalid),
    .i_tready     (i_tready),
    .o_tdata      (o_tdata),
    .o_tlast      (o_tlast),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_error      (o_error)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor on the falling edge: handshakes are checked against the scoreboard,
  // and stalled words must stay unchanged.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_tvalid", {31'd0, o_tvalid}, 32'd1);
        chk("hold_word", {23'd0, o_tlast, o_tdata}, {23'd0, prev_word});
      end
      if (o_tvalid && i_tready) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_word", {23'd0, o_tlast, o_tdata}, 32'hFFFF_FFFF);
        end else begin
          chk("word", {23'd0, o_tlast, o_tdata}, {23'd0, sb_q.pop_front()});
        end
      end
      prev_stall = o_tvalid && !i_tready;
      prev_word  = {o_tlast, o_tdata};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [7:0] w, input int nbits);
    for (int b = 7; b > 7 - nbits; b--) begin
      i_ser_data = w[b];
      i_ser_clk  = 1'b0;
      tick();
      tick();
      i_ser_clk  = 1'b1;
      tick();
      tick();
    end
  endtask

  task automatic send_word(input logic [7:0] w, input logic last, input logic expect_out);
    if (expect_out) sb_q.push_back({last, w});
    send_bits(w, 8);
  endtask

  task automatic start_load(input string tag);
    tick();
    i_load_start = 1'b1;
    tick();
    i_load_start = 1'b0;
    chk({tag, "_cfg_pulse"}, {31'd0, o_cfg}, 32'd1);
    chk({tag, "_busy"}, {31'd0, o_busy}, 32'd1);
    chk({tag, "_done_low"}, {31'd0, o_done}, 32'd0);
    tick();
    chk({tag, "_cfg_one_cycle"}, {31'd0, o_cfg}, 32'd0);
  endtask

  task automatic wait_done(input string tag);
    for (int c = 0; c < 600; c++) begin
      if (o_done) break;
      tick();
    end
    chk({tag, "_done"}, {31'd0, o_done}, 32'd1);
    chk({tag, "_busy_low"}, {31'd0, o_busy}, 32'd0);
    chk({tag, "_all_words_out"}, sb_q.size(), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not end, required end before 2 ms");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{8'h01, 1'b0}; tbl[1]  = '{8'h02, 1'b0}; tbl[2]  = '{8'h03, 1'b1};
    tbl[3]  = '{8'h04, 1'b0}; tbl[4]  = '{8'h05, 1'b0}; tbl[5]  = '{8'h06, 1'b1};
    tbl[6]  = '{8'h07, 1'b0}; tbl[7]  = '{8'h08, 1'b0}; tbl[8]  = '{8'h09, 1'b1};
    tbl[9]  = '{8'h0A, 1'b0}; tbl[10] = '{8'h0B, 1'b0}; tbl[11] = '{8'h0C, 1'b1};

    rst_n = 1'b0; i_load_start = 1'b0; i_ser_clk = 1'b0; i_ser_data = 1'b0; i_tready = 1'b1;

    // Reset with serial activity
    for (int c = 0; c < 3; c++) begin
      i_ser_clk  = ~i_ser_clk;
      i_ser_data = ~i_ser_data;
      tick();
      chk("rst_tvalid", {31'd0, o_tvalid}, 32'd0);
      chk("rst_cfg", {31'd0, o_cfg}, 32'd0);
      chk("rst_busy", {31'd0, o_busy}, 32'd0);
      chk("rst_done", {31'd0, o_done}, 32'd0);
      chk("rst_error", {31'd0, o_error}, 32'd0);
      chk("rst_tdata", {24'd0, o_tdata}, 32'd0);
    end
    rst_n = 1'b1; i_ser_clk = 1'b0; i_ser_data = 1'b0;
    repeat (6) tick();
    chk("idle_tvalid", {31'd0, o_tvalid}, 32'd0);
    chk("idle_busy", {31'd0, o_busy}, 32'd0);

    // Nominal load from table
    start_load("nom");
    for (int i = 0; i < 12; i++) send_word(tbl[i].data, tbl[i].last, 1'b1);
    wait_done("nom");
    chk("nom_error", {31'd0, o_error}, 32'd0);

    // Backpressure on words 1-2 (reload from DONE)
    start_load("bp");
    i_tready = 1'b0;
    send_word(tbl[0].data, tbl[0].last, 1'b1);
    send_word(tbl[1].data, tbl[1].last, 1'b1);
    repeat (4) tick();
    chk("bp_tvalid", {31'd0, o_tvalid}, 32'd1);
    chk("bp_tdata_head", {24'd0, o_tdata}, 32'h01);
    i_tready = 1'b1;
    for (int i = 2; i < 12; i++) send_word(tbl[i].data, tbl[i].last, 1'b1);
    wait_done("bp");
    chk("bp_error", {31'd0, o_error}, 32'd0);

    // Overflow: tready low for the whole load
    start_load("ovf");
    i_tready = 1'b0;
    send_word(tbl[0].data, tbl[0].last, 1'b1);
    send_word(tbl[1].data, tbl[1].last, 1'b1);
    repeat (4) tick();
    chk("ovf_error_before", {31'd0, o_error}, 32'd0);
    send_word(tbl[2].data, tbl[2].last, 1'b0);
    repeat (4) tick();
    chk("ovf_error_third", {31'd0, o_error}, 32'd1);
    for (int i = 3; i < 12; i++) send_word(tbl[i].data, tbl[i].last, 1'b0);
    repeat (10) tick();
    chk("ovf_stuck_done", {31'd0, o_done}, 32'd0);
    chk("ovf_stuck_busy", {31'd0, o_busy}, 32'd1);
    chk("ovf_head", {23'd0, o_tlast, o_tdata}, 32'h001);
    i_tready = 1'b1;
    wait_done("ovf");
    chk("ovf_error_sticky", {31'd0, o_error}, 32'd1);

    // Reload from DONE clears error and frames a new bitstream
    start_load("rl");
    chk("rl_error_cleared", {31'd0, o_error}, 32'd0);
    for (int i = 0; i < 12; i++) send_word(tbl[i].data ^ 8'hA5, tbl[i].last, 1'b1);
    wait_done("rl");
    chk("rl_error", {31'd0, o_error}, 32'd0);

    // Mid-load load_start ignored, then reset mid-word 5
    start_load("rs");
    send_word(8'h11, 1'b0, 1'b1);
    i_load_start = 1'b1;
    tick();
    i_load_start = 1'b0;
    chk("rs_ignore_cfg", {31'd0, o_cfg}, 32'd0);
    tick();
    chk("rs_ignore_cfg2", {31'd0, o_cfg}, 32'd0);
    chk("rs_ignore_busy", {31'd0, o_busy}, 32'd1);
    send_word(8'h12, 1'b0, 1'b1);
    send_word(8'h13, 1'b1, 1'b1);
    send_word(8'h14, 1'b0, 1'b1);
    send_bits(8'hFF, 4);
    repeat (4) tick();
    chk("rs_pre_reset_words_out", sb_q.size(), 32'd0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    i_ser_clk = 1'b0;
    chk("rs_tvalid", {31'd0, o_tvalid}, 32'd0);
    chk("rs_busy", {31'd0, o_busy}, 32'd0);
    chk("rs_done", {31'd0, o_done}, 32'd0);
    repeat (6) tick();
    chk("rs_idle_tvalid", {31'd0, o_tvalid}, 32'd0);
    start_load("rs2");
    send_word(8'h31, 1'b0, 1'b1);
    send_word(8'h32, 1'b0, 1'b1);
    send_word(8'h33, 1'b1, 1'b1);
    repeat (8) tick();
    chk("rs2_words_out", sb_q.size(), 32'd0);
    chk("rs2_busy", {31'd0, o_busy}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
